// File: rtl/obi_mem_port_arbiter.sv
// Round-robin arbiter sharing one OBI memory port between instruction and data requesters.
// An ID FIFO routes in-order responses back to whichever requester issued them.
module obi_mem_port_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   instr_req_i,
    input  logic [ADDR_WIDTH-1:0]                  instr_addr_i,
    output logic                                   instr_gnt_o,
    output logic                                   instr_rvalid_o,
    output logic [31:0]                            instr_rdata_o,
    input  logic                                   data_req_i,
    input  logic [ADDR_WIDTH-1:0]                  data_addr_i,
    input  logic                                   data_we_i,
    input  logic [3:0]                             data_be_i,
    input  logic [31:0]                            data_wdata_i,
    output logic                                   data_gnt_o,
    output logic                                   data_rvalid_o,
    output logic [31:0]                            data_rdata_o,
    output logic                                   m_req_o,
    output logic [ADDR_WIDTH-1:0]                  m_addr_o,
    output logic                                   m_we_o,
    output logic [3:0]                             m_be_o,
    output logic [31:0]                            m_wdata_o,
    input  logic                                   m_gnt_i,
    input  logic                                   m_rvalid_i,
    input  logic [31:0]                            m_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   err_o
);

    // state         | meaning
    // ST_OPEN       | no pending address phase; selection follows requests and priority
    // ST_HOLD_INSTR | instr request waiting for grant; selection pinned to instr
    // ST_HOLD_DATA  | data request waiting for grant; selection pinned to data

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

    typedef enum logic {
        REQ_INSTR = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_e;

    typedef enum logic [1:0] {
        ST_OPEN       = 2'd0,
        ST_HOLD_INSTR = 2'd1,
        ST_HOLD_DATA  = 2'd2
    } lock_state_e;

    lock_state_e state_q, state_d;
    req_id_e     prio_q, prio_d;
    req_id_e     sel;

    logic [MAX_OUTSTANDING-1:0] fifo_q;
    logic [PW-1:0]              head_q, tail_q;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       err_q;

    logic sel_req;
    logic m_req;
    logic accept;
    logic resp_ok;
    logic head_is_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        sel = prio_q;
        case (state_q)
            ST_HOLD_INSTR: sel = REQ_INSTR;
            ST_HOLD_DATA:  sel = REQ_DATA;
            default: begin
                if (instr_req_i && !data_req_i) begin
                    sel = REQ_INSTR;
                end else if (data_req_i && !instr_req_i) begin
                    sel = REQ_DATA;
                end
            end
        endcase
    end

    assign sel_req      = (sel == REQ_DATA) ? data_req_i : instr_req_i;
    assign m_req        = rst_ni & sel_req & (cnt_q < MAX_CNT);
    assign accept       = m_req & m_gnt_i;
    assign resp_ok      = rst_ni & m_rvalid_i & (cnt_q != '0);
    assign head_is_data = fifo_q[head_q];

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        if (accept) begin
            state_d = ST_OPEN;
            prio_d  = (sel == REQ_DATA) ? REQ_INSTR : REQ_DATA;
        end else if (m_req) begin
            state_d = (sel == REQ_DATA) ? ST_HOLD_DATA : ST_HOLD_INSTR;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_OPEN;
            prio_q  <= REQ_INSTR;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({accept, resp_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // A response with nothing outstanding is a protocol violation; it stays flagged until reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fifo_q <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                fifo_q[tail_q] <= (sel == REQ_DATA);
                tail_q         <= ptr_inc(tail_q);
            end
            if (resp_ok) begin
                head_q <= ptr_inc(head_q);
            end
            cnt_q <= cnt_d;
            if (m_rvalid_i && (cnt_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign m_req_o   = m_req;
    assign m_addr_o  = (sel == REQ_DATA) ? data_addr_i : instr_addr_i;
    assign m_we_o    = (sel == REQ_DATA) & data_we_i;
    assign m_be_o    = (sel == REQ_DATA) ? data_be_i : 4'hF;
    assign m_wdata_o = (sel == REQ_DATA) ? data_wdata_i : 32'h0;

    assign instr_gnt_o    = accept & (sel == REQ_INSTR);
    assign data_gnt_o     = accept & (sel == REQ_DATA);
    assign instr_rvalid_o = resp_ok & ~head_is_data;
    assign data_rvalid_o  = resp_ok & head_is_data;
    assign instr_rdata_o  = m_rdata_i;
    assign data_rdata_o   = m_rdata_i;

    assign outstanding_o = cnt_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_obi_mem_port_arbiter.sv
// Self-checking bench for obi_mem_port_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_obi_mem_port_arbiter;

    localparam int MAXO = 2;
    localparam int AW   = 32;
    localparam int CW   = $clog2(MAXO + 1);

    logic          clk;
    logic          rst_n;
    logic          ireq, dreq, dwe, mgnt, mrv;
    logic [AW-1:0] iaddr, daddr;
    logic [3:0]    dbe;
    logic [31:0]   dwdata, mrdata;

    logic          igt, irv, dgt, drv, m_req, m_we, err;
    logic [31:0]   irdata, drdata, m_wdata;
    logic [AW-1:0] m_addr;
    logic [3:0]    m_be;
    logic [CW-1:0] outst;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state: requester 0 = instr, 1 = data
    int mq[$];
    bit m_lock;
    int m_who;
    int m_prio;
    bit m_err;

    int          e_sel;
    bit          e_mreq, e_igt, e_dgt, e_irv, e_drv, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;

    obi_mem_port_arbiter #(.MAX_OUTSTANDING(MAXO), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(ireq), .instr_addr_i(iaddr), .instr_gnt_o(igt),
        .instr_rvalid_o(irv), .instr_rdata_o(irdata),
        .data_req_i(dreq), .data_addr_i(daddr), .data_we_i(dwe), .data_be_i(dbe),
        .data_wdata_i(dwdata), .data_gnt_o(dgt), .data_rvalid_o(drv), .data_rdata_o(drdata),
        .m_req_o(m_req), .m_addr_o(m_addr), .m_we_o(m_we), .m_be_o(m_be), .m_wdata_o(m_wdata),
        .m_gnt_i(mgnt), .m_rvalid_i(mrv), .m_rdata_i(mrdata),
        .outstanding_o(outst), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_eval();
        bit want;
        if (m_lock)            e_sel = m_who;
        else if (ireq && !dreq) e_sel = 0;
        else if (dreq && !ireq) e_sel = 1;
        else                   e_sel = m_prio;
        want    = (e_sel == 1) ? dreq : ireq;
        e_mreq  = rst_n && want && (mq.size() < MAXO);
        e_igt   = e_mreq && mgnt && (e_sel == 0);
        e_dgt   = e_mreq && mgnt && (e_sel == 1);
        e_irv   = rst_n && mrv && (mq.size() > 0) && (mq[0] == 0);
        e_drv   = rst_n && mrv && (mq.size() > 0) && (mq[0] == 1);
        e_addr  = (e_sel == 1) ? daddr : iaddr;
        e_we    = (e_sel == 1) ? dwe : 1'b0;
        e_be    = (e_sel == 1) ? dbe : 4'hF;
        e_wdata = (e_sel == 1) ? dwdata : 32'h0;
    endfunction

    function automatic void model_update();
        if (!rst_n) begin
            mq.delete();
            m_lock = 0;
            m_prio = 0;
            m_err  = 0;
        end else begin
            if (mrv) begin
                if (mq.size() > 0) void'(mq.pop_front());
                else m_err = 1;
            end
            if (e_mreq && mgnt) begin
                mq.push_back(e_sel);
                m_lock = 0;
                m_prio = 1 - e_sel;
            end else if (e_mreq) begin
                m_lock = 1;
                m_who  = e_sel;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_eval();
        model_update();
        #1;
    endtask

    task automatic idle();
        ireq = 0; dreq = 0; dwe = 0; mgnt = 0; mrv = 0;
        iaddr = '0; daddr = '0; dbe = 4'h0; dwdata = '0; mrdata = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        ireq = 1; dreq = 1; mgnt = 1; mrv = 1;
        #1;
        n_cmp++;
        if ({m_req, igt, dgt, irv, drv} !== 5'b0) begin
            n_err++; $display("FAIL reset_forced: got %b want 00000", {m_req, igt, dgt, irv, drv});
        end
        tick();
        n_cmp++;
        if ({outst, err} !== {CW'(0), 1'b0}) begin
            n_err++; $display("FAIL reset_state: outstanding=%0d err=%b want 0 0", outst, err);
        end
        do_reset();
    endtask

    task automatic test_single_instr();
        do_reset();
        ireq = 1; iaddr = 32'h80; mgnt = 1;
        #1;
        n_cmp++;
        if ({igt, dgt, m_we, m_be, outst} !== {1'b1, 1'b0, 1'b0, 4'hF, CW'(0)}) begin
            n_err++; $display("FAIL single_c0: gnt=%b/%b we=%b be=%h outst=%0d want 1/0 0 f 0", igt, dgt, m_we, m_be, outst);
        end
        tick();
        ireq = 0; mgnt = 0; mrv = 1; mrdata = 32'h0000_0013;
        #1;
        n_cmp++;
        if ({irv, drv, irdata, outst} !== {1'b1, 1'b0, 32'h13, CW'(1)}) begin
            n_err++; $display("FAIL single_c1: rv=%b/%b rdata=%h outst=%0d want 1/0 13 1", irv, drv, irdata, outst);
        end
        tick();
        mrv = 0;
        #1;
        n_cmp++;
        if (outst !== CW'(0)) begin
            n_err++; $display("FAIL single_c2: outstanding=%0d want 0", outst);
        end
    endtask

    task automatic test_alternate();
        bit [3:0] exp_v;
        do_reset();
        ireq = 1; dreq = 1; mgnt = 1;
        for (int k = 0; k < 8; k++) begin
            mrv = (k > 0); mrdata = k;
            #1;
            exp_v = {k % 2 == 0, k % 2 == 1, k > 0 && (k - 1) % 2 == 0, k > 0 && (k - 1) % 2 == 1};
            n_cmp++;
            if ({igt, dgt, irv, drv} !== exp_v) begin
                n_err++; $display("FAIL alternate[%0d]: gnt/rv=%b want %b", k, {igt, dgt, irv, drv}, exp_v);
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_lock();
        do_reset();
        dreq = 1; daddr = 32'h1000; dbe = 4'h3; iaddr = 32'h2000;
        for (int k = 0; k < 4; k++) begin
            ireq = (k >= 1);
            mgnt = (k == 3);
            #1;
            n_cmp++;
            if ({m_req, igt, dgt, m_addr, m_be} !== {1'b1, 1'b0, k == 3, 32'h1000, 4'h3}) begin
                n_err++; $display("FAIL lock[%0d]: req=%b gnt=%b/%b addr=%h be=%h want 1 0/%0d 1000 3", k, m_req, igt, dgt, m_addr, m_be, k == 3);
            end
            tick();
        end
        dreq = 0; mgnt = 1;
        #1;
        n_cmp++;
        if ({igt, dgt, m_addr} !== {1'b1, 1'b0, 32'h2000}) begin
            n_err++; $display("FAIL lock_c4: gnt=%b/%b addr=%h want 1/0 2000", igt, dgt, m_addr);
        end
        tick();
        idle(); mrv = 1;
        tick();
        tick();
        mrv = 0;
    endtask

    task automatic test_full();
        do_reset();
        ireq = 1; mgnt = 1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++;
            if (igt !== 1'b1) begin
                n_err++; $display("FAIL full_gnt[%0d]: got %b want 1", k, igt);
            end
            tick();
        end
        mrv = 1;
        #1;
        n_cmp++;
        if ({outst, m_req, igt, irv} !== {CW'(2), 1'b0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL full_stall: outst=%0d req=%b gnt=%b rv=%b want 2 0 0 1", outst, m_req, igt, irv);
        end
        tick();
        mrv = 0; mgnt = 0;
        #1;
        n_cmp++;
        if ({outst, m_req} !== {CW'(1), 1'b1}) begin
            n_err++; $display("FAIL full_release: outst=%0d req=%b want 1 1", outst, m_req);
        end
        tick();
        idle(); mrv = 1;
        tick();
        mrv = 0;
    endtask

    task automatic test_simul();
        do_reset();
        ireq = 1; mgnt = 1;
        tick();
        ireq = 0; dreq = 1; mrv = 1;
        #1;
        n_cmp++;
        if ({dgt, irv, drv} !== 3'b110) begin
            n_err++; $display("FAIL simul_c1: dgnt=%b rv=%b/%b want 1 1/0", dgt, irv, drv);
        end
        tick();
        dreq = 0; mgnt = 0;
        #1;
        n_cmp++;
        if ({outst, irv, drv} !== {CW'(1), 1'b0, 1'b1}) begin
            n_err++; $display("FAIL simul_c2: outst=%0d rv=%b/%b want 1 0/1", outst, irv, drv);
        end
        tick();
        mrv = 0;
        #1;
        n_cmp++;
        if (outst !== CW'(0)) begin
            n_err++; $display("FAIL simul_c3: outstanding=%0d want 0", outst);
        end
    endtask

    task automatic test_err_empty();
        do_reset();
        mrv = 1; mrdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if ({irv, drv, err} !== 3'b000) begin
            n_err++; $display("FAIL err_cycle: rv=%b/%b err=%b want 0/0 0", irv, drv, err);
        end
        tick();
        mrv = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (err !== 1'b1) begin
                n_err++; $display("FAIL err_sticky[%0d]: got %b want 1", k, err);
            end
            tick();
        end
        rst_n = 0;
        tick();
        n_cmp++;
        if (err !== 1'b0) begin
            n_err++; $display("FAIL err_reset: got %b want 0", err);
        end
        rst_n = 1;
    endtask

    task automatic test_random();
        logic [151:0] act, exp_v;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            rst_n  = ($urandom_range(0, 199) != 0);
            ireq   = $urandom_range(0, 3) != 0;
            dreq   = $urandom_range(0, 2) != 0;
            iaddr  = $urandom; daddr = $urandom; dwdata = $urandom;
            dwe    = $urandom_range(0, 1); dbe = 4'($urandom);
            mgnt   = $urandom_range(0, 2) != 0;
            mrdata = $urandom;
            mrv    = (mq.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 99) == 0);
            #1;
            model_eval();
            act   = {m_req, igt, dgt, irv, drv, m_addr, m_we, m_be, m_wdata, 6'(outst), err, irdata, drdata[14:0]};
            exp_v = {e_mreq, e_igt, e_dgt, e_irv, e_drv, e_addr, e_we, e_be, e_wdata, 6'(mq.size()), m_err, mrdata, mrdata[14:0]};
            n_cmp++;
            if (act !== exp_v) begin
                n_err++; $display("FAIL random[%0d]: got %h want %h", k, act, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 0;
        mq.delete();
        m_lock = 0; m_who = 0; m_prio = 0; m_err = 0;
        test_reset();
        test_single_instr();
        test_alternate();
        test_lock();
        test_full();
        test_simul();
        test_err_empty();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
